// File: rtl/bus_server_memory.sv
// Bus server target: register-file memory behind the 4-client arbiter, with
// programmable wait states, a one-cycle ack pulse and saturating statistics.
module bus_server_memory #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int WAIT_STATES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] server_address,
    input  logic                  server_rq,
    output logic                  server_ack,
    input  logic                  server_wr_ni,
    input  logic [DATA_WIDTH-1:0] server_dataW,
    output logic [DATA_WIDTH-1:0] server_dataR,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count,
    output logic [CNT_WIDTH-1:0]  abort_count
);

    localparam int Depth = 2 ** ADDR_WIDTH;
    localparam logic [7:0] WaitInit = 8'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] dataW_q;
    logic [DATA_WIDTH-1:0] dataR_q;
    logic                  wrNi_q;
    logic [7:0]            cnt_q;
    logic [CNT_WIDTH-1:0]  rdCount_q;
    logic [CNT_WIDTH-1:0]  wrCount_q;
    logic [CNT_WIDTH-1:0]  abortCount_q;
    logic [CNT_WIDTH-1:0]  rdCount_d;
    logic [CNT_WIDTH-1:0]  wrCount_d;
    logic [CNT_WIDTH-1:0]  abortCount_d;
    logic [DATA_WIDTH-1:0] mem_q [Depth];

    // Saturating increments: counters stick at all-ones instead of wrapping.
    always_comb begin
        rdCount_d    = (rdCount_q    == '1) ? rdCount_q    : rdCount_q    + 1'b1;
        wrCount_d    = (wrCount_q    == '1) ? wrCount_q    : wrCount_q    + 1'b1;
        abortCount_d = (abortCount_q == '1) ? abortCount_q : abortCount_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            dataW_q      <= '0;
            dataR_q      <= '0;
            wrNi_q       <= 1'b0;
            cnt_q        <= '0;
            rdCount_q    <= '0;
            wrCount_q    <= '0;
            abortCount_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (server_rq) begin
                        addr_q  <= server_address;
                        dataW_q <= server_dataW;
                        wrNi_q  <= server_wr_ni;
                        cnt_q   <= WaitInit;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // A withdrawn request aborts even when the wait count has expired.
                    if (!server_rq) begin
                        abortCount_q <= abortCount_d;
                        state_q      <= IDLE;
                    end else if (cnt_q == 8'd0) begin
                        if (wrNi_q) begin
                            mem_q[addr_q] <= dataW_q;
                            dataR_q       <= '0;
                            wrCount_q     <= wrCount_d;
                        end else begin
                            dataR_q   <= mem_q[addr_q];
                            rdCount_q <= rdCount_d;
                        end
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign server_ack   = (state_q == ACK);
    assign busy         = (state_q == BUSY) || (state_q == ACK);
    assign server_dataR = dataR_q;
    assign rd_count     = rdCount_q;
    assign wr_count     = wrCount_q;
    assign abort_count  = abortCount_q;

endmodule

// File: tb/tb_bus_server_memory.sv
// Scoreboard bench: instance 0 uses two wait states and 16-bit counters,
// instance 1 uses zero wait states and 4-bit counters to reach saturation.
module tb_bus_server_memory;

    typedef struct packed {
        logic [31:0] cycle;
        logic [7:0]  data;
    } expEntry_t;

    logic       clk;
    logic       reset [2];
    logic       rq [2];
    logic       wrNi [2];
    logic [3:0] addr [2];
    logic [7:0] dataW [2];
    logic       ack [2];
    logic       busy [2];
    logic [7:0] dataR [2];

    logic [15:0] rdCntA, wrCntA, abortCntA;
    logic [3:0]  rdCntB, wrCntB, abortCntB;

    int testsRun = 0;
    int testsFailed = 0;
    int edgeCount = 0;

    expEntry_t expQA[$];
    expEntry_t expQB[$];
    expEntry_t popA;
    expEntry_t popB;

    bus_server_memory #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .WAIT_STATES(2), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset[0]), .server_address(addr[0]), .server_rq(rq[0]),
        .server_ack(ack[0]), .server_wr_ni(wrNi[0]), .server_dataW(dataW[0]),
        .server_dataR(dataR[0]), .busy(busy[0]), .rd_count(rdCntA),
        .wr_count(wrCntA), .abort_count(abortCntA)
    );

    bus_server_memory #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .WAIT_STATES(0), .CNT_WIDTH(4)
    ) dut0 (
        .clk(clk), .reset(reset[1]), .server_address(addr[1]), .server_rq(rq[1]),
        .server_ack(ack[1]), .server_wr_ni(wrNi[1]), .server_dataW(dataW[1]),
        .server_dataR(dataR[1]), .busy(busy[1]), .rd_count(rdCntB),
        .wr_count(wrCntB), .abort_count(abortCntB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edgeCount);
        end
    endtask

    // Monitors: every ack must match the oldest pending expectation in cycle and data.
    always @(negedge clk) begin
        if (ack[0] === 1'b1) begin
            if (expQA.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpectedAckA: ack=1 with nothing pending at edge %0d", edgeCount);
            end else begin
                popA = expQA.pop_front();
                checkOutput("ackCycleA", 32'(edgeCount), popA.cycle);
                checkOutput("dataRA", 32'(dataR[0]), 32'(popA.data));
            end
        end
    end

    always @(negedge clk) begin
        if (ack[1] === 1'b1) begin
            if (expQB.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpectedAckB: ack=1 with nothing pending at edge %0d", edgeCount);
            end else begin
                popB = expQB.pop_front();
                checkOutput("ackCycleB", 32'(edgeCount), popB.cycle);
                checkOutput("dataRB", 32'(dataR[1]), 32'(popB.data));
            end
        end
    end

    function automatic int waitStates(input int inst);
        return (inst == 0) ? 2 : 0;
    endfunction

    // Single transaction: rq held until ack, request fields scrambled after latching.
    task automatic applyStimulus(input int inst, input logic wr, input logic [3:0] a,
                                 input logic [7:0] d, input logic [7:0] expData);
        bit got;
        expEntry_t e;
        @(negedge clk);
        rq[inst]    = 1'b1;
        wrNi[inst]  = wr;
        addr[inst]  = a;
        dataW[inst] = d;
        e.cycle = 32'(edgeCount + waitStates(inst) + 2);
        e.data  = expData;
        if (inst == 0) expQA.push_back(e);
        else expQB.push_back(e);
        @(negedge clk);
        wrNi[inst]  = ~wr;
        addr[inst]  = ~a;
        dataW[inst] = ~d;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ack[inst] === 1'b1) begin
                got = 1'b1;
                break;
            end
            checkOutput("busyWait", 32'(busy[inst]), 32'd1);
            @(negedge clk);
        end
        if (!got) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL ackTimeout: no ack on instance %0d", inst);
        end else begin
            checkOutput("busyAck", 32'(busy[inst]), 32'd1);
        end
        rq[inst] = 1'b0;
        @(negedge clk);
        checkOutput("busyIdle", 32'(busy[inst]), 32'd0);
    endtask

    task automatic resetBoth();
        reset[0] = 1'b1;
        reset[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rq[i] = 1'b0; wrNi[i] = 1'b0; addr[i] = '0; dataW[i] = '0;
        end
        repeat (2) @(negedge clk);
        reset[0] = 1'b0;
        reset[1] = 1'b0;
    endtask

    initial begin
        int acks;
        expEntry_t e;

        resetBoth();
        checkOutput("rstAck", 32'(ack[0]), 32'd0);
        checkOutput("rstBusy", 32'(busy[0]), 32'd0);
        checkOutput("rstDataR", 32'(dataR[0]), 32'd0);
        checkOutput("rstRdCnt", 32'(rdCntA), 32'd0);
        checkOutput("rstWrCnt", 32'(wrCntA), 32'd0);
        checkOutput("rstAbortCnt", 32'(abortCntA), 32'd0);

        // Write then read back on the two-wait-state instance.
        applyStimulus(0, 1'b1, 4'h3, 8'hA5, 8'h00);
        checkOutput("wrCountAfterWrite", 32'(wrCntA), 32'd1);
        applyStimulus(0, 1'b0, 4'h3, 8'h00, 8'hA5);
        checkOutput("rdCountAfterRead", 32'(rdCntA), 32'd1);
        applyStimulus(0, 1'b0, 4'h7, 8'h00, 8'h00);
        checkOutput("rdCountTwoReads", 32'(rdCntA), 32'd2);

        // Withdrawn write to addr 3 must abort without touching memory.
        @(negedge clk);
        rq[0] = 1'b1; wrNi[0] = 1'b1; addr[0] = 4'h3; dataW[0] = 8'hFF;
        @(negedge clk);
        rq[0] = 1'b0;
        @(negedge clk);
        checkOutput("abortBusy", 32'(busy[0]), 32'd0);
        checkOutput("abortCount", 32'(abortCntA), 32'd1);
        checkOutput("abortWrCount", 32'(wrCntA), 32'd1);
        repeat (4) @(negedge clk);
        applyStimulus(0, 1'b0, 4'h3, 8'h00, 8'hA5);

        // Reset on the edge that would commit a write to addr 1.
        @(negedge clk);
        rq[0] = 1'b1; wrNi[0] = 1'b1; addr[0] = 4'h1; dataW[0] = 8'h5A;
        repeat (3) @(negedge clk);
        reset[0] = 1'b1;
        rq[0] = 1'b0;
        @(negedge clk);
        reset[0] = 1'b0;
        checkOutput("midRstBusy", 32'(busy[0]), 32'd0);
        checkOutput("midRstRdCnt", 32'(rdCntA), 32'd0);
        checkOutput("midRstWrCnt", 32'(wrCntA), 32'd0);
        checkOutput("midRstAbortCnt", 32'(abortCntA), 32'd0);
        checkOutput("midRstDataR", 32'(dataR[0]), 32'd0);
        applyStimulus(0, 1'b0, 4'h1, 8'h00, 8'h00);
        applyStimulus(0, 1'b0, 4'h3, 8'h00, 8'h00);

        // Zero-wait instance: write, then three back-to-back reads with rq held.
        applyStimulus(1, 1'b1, 4'h5, 8'h3C, 8'h00);
        checkOutput("wrCountB", 32'(wrCntB), 32'd1);
        @(negedge clk);
        rq[1] = 1'b1; wrNi[1] = 1'b0; addr[1] = 4'h5;
        for (int j = 0; j < 3; j++) begin
            e.cycle = 32'(edgeCount + 2 + 3 * j);
            e.data  = 8'h3C;
            expQB.push_back(e);
        end
        acks = 0;
        for (int i = 0; i < 30 && acks < 3; i++) begin
            @(negedge clk);
            if (ack[1] === 1'b1) acks++;
        end
        rq[1] = 1'b0;
        checkOutput("backToBackAcks", 32'(acks), 32'd3);
        repeat (2) @(negedge clk);
        checkOutput("rdCountB3", 32'(rdCntB), 32'd3);

        // Drive the 4-bit read counter to all-ones and past it.
        for (int i = 0; i < 12; i++) applyStimulus(1, 1'b0, 4'h5, 8'h00, 8'h3C);
        checkOutput("rdCountB15", 32'(rdCntB), 32'd15);
        for (int i = 0; i < 2; i++) applyStimulus(1, 1'b0, 4'h5, 8'h00, 8'h3C);
        checkOutput("rdCountSaturated", 32'(rdCntB), 32'd15);
        checkOutput("abortCountB", 32'(abortCntB), 32'd0);

        repeat (3) @(negedge clk);
        checkOutput("pendingA", 32'(expQA.size()), 32'd0);
        checkOutput("pendingB", 32'(expQB.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/bus_server_memory.md
Name: bus_server_memory

Overview:
- Server-side target sitting directly downstream of the 4-client bus arbiter; consumes its server_address / server_rq / server_wr_ni / server_dataW and returns server_ack / server_dataR.
- Register-file memory of 2**ADDR_WIDTH words with a programmable number of wait states.
- One-cycle ack pulse per completed transaction; requests withdrawn mid-wait are aborted.
- Saturating read/write/abort statistics counters.

Parameters:
- DATA_WIDTH, 8, data word width; matches the arbiter.
- ADDR_WIDTH, 4, address width; memory depth = 2**ADDR_WIDTH.
- WAIT_STATES, 2, extra BUSY cycles before ack; legal range 0..255.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- server_address  input  ADDR_WIDTH  word address from the arbiter.
- server_rq  input  1  request; held high by the client until ack.
- server_ack  output  1  one-cycle completion pulse.
- server_wr_ni  input  1  1 = write, 0 = read.
- server_dataW  input  DATA_WIDTH  write data.
- server_dataR  output  DATA_WIDTH  read data; valid while server_ack = 1.
- busy  output  1  high in BUSY and ACK states.
- rd_count  output  CNT_WIDTH  completed reads, saturating.
- wr_count  output  CNT_WIDTH  completed writes, saturating.
- abort_count  output  CNT_WIDTH  aborted requests, saturating.

Behaviour:
- Reset values: the following apply when reset is high at an edge.
  - State = IDLE.
  - server_ack = 0, busy = 0, server_dataR = 0.
  - All counters = 0, all memory words = 0.
  - Latched address, data and wr_ni = 0.
- Reset has priority over every other event. Reset mid-BUSY or mid-ACK returns to IDLE; no memory write and no counter update occur for the interrupted transaction.
- FSM states: IDLE, BUSY, ACK. All outputs are registered or decoded from state; there is no combinational path from server_rq to server_ack.
- IDLE:
  - If server_rq = 1 at edge k, latch server_address, server_wr_ni and server_dataW, load wait counter cnt = WAIT_STATES, and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If server_rq = 0, go to IDLE and increment abort_count. No memory access occurs. Abort takes priority over cnt = 0.
  - Else if cnt = 0, go to ACK and perform the access on the same edge:
    - Write (latched wr_ni = 1): mem[addr] <= latched dataW; server_dataR <= 0; wr_count++.
    - Read: server_dataR <= mem[addr]; rd_count++.
  - Else cnt <= cnt - 1.
- ACK:
  - server_ack = 1 for exactly one cycle.
  - Next state is always IDLE, regardless of server_rq. This guarantees at least one IDLE cycle between transactions, which lets the arbiter re-select after ack.
- Latency: with rq sampled at edge k, ack rises after edge k+WAIT_STATES+1 and falls after edge k+WAIT_STATES+2.
  - WAIT_STATES = 0 gives a 2-edge request-to-ack latency.
  - Back-to-back requests with rq held high are restarted from IDLE at edge k+WAIT_STATES+3.
- Request fields are taken from the latch only. Changes to address, data or wr_ni after edge k have no effect on the transaction.
- server_dataR holds its last loaded value outside ACK. Only the ACK cycle is architecturally valid.
- Counters saturate at all-ones and never wrap.
- Read-after-write to the same address returns the new data, because the write commits on the edge entering ACK.
- server_rq observed in the ACK cycle is ignored and produces no abort.

Test Plan:
- Reset, then WAIT_STATES=2: write addr 0x3 data 0xA5, rq held from edge 1 -> ack high only in the cycle after edge 4; wr_count=1; busy high during edges 1..4.
- Read addr 0x3 after the previous write -> server_dataR=0xA5 during the ack cycle; rd_count=1; read of untouched addr 0x7 returns 0x00.
- Request withdrawn: rq high at edge 1, low before edge 2 (WAIT_STATES=2) -> FSM returns to IDLE, no ack, abort_count=1, memory unchanged.
- rq held high continuously for 3 reads with WAIT_STATES=0 -> acks after edges 2, 5 and 8 (period 3); rd_count=3.
- Reset asserted in BUSY during a write to addr 0x1 -> IDLE next cycle; mem[0x1] reads 0x00; all counters read 0.
- Force rd_count to 0xFFFF (CNT_WIDTH=16), complete another read -> rd_count stays at 0xFFFF.
